// File: rtl/dev_audio_pkg.sv
// Shared rate codes, controller state encoding and the rate-code to PLL pin map
// for the PLL1707-class audio clock generator.
package dev_audio_pkg;

   localparam logic [15:0] FREQ_32K  = 16'h1;
   localparam logic [15:0] FREQ_441K = 16'h2;
   localparam logic [15:0] FREQ_48K  = 16'h3;
   localparam logic [15:0] FREQ_96K  = 16'h4;
   localparam logic [15:0] FREQ_64K  = 16'h5;
   localparam logic [15:0] FREQ_882K = 16'h6;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_MUTE   = 2'd1;
   localparam logic [1:0] ST_PROG   = 2'd2;
   localparam logic [1:0] ST_SETTLE = 2'd3;

   typedef struct packed {
      logic       valid;
      logic       sr;
      logic [1:0] fs;
   } pll_pins_t;

   function automatic pll_pins_t rate_to_pins(input logic [15:0] code);
      pll_pins_t p;
      p = '{valid: 1'b0, sr: 1'b0, fs: 2'b00};
      case (code)
         FREQ_32K:  p = '{valid: 1'b1, sr: 1'b0, fs: 2'b10};
         FREQ_441K: p = '{valid: 1'b1, sr: 1'b0, fs: 2'b01};
         FREQ_48K:  p = '{valid: 1'b1, sr: 1'b0, fs: 2'b00};
         FREQ_96K:  p = '{valid: 1'b1, sr: 1'b1, fs: 2'b00};
         FREQ_64K:  p = '{valid: 1'b1, sr: 1'b1, fs: 2'b10};
         FREQ_882K: p = '{valid: 1'b1, sr: 1'b1, fs: 2'b01};
         default:   p = '{valid: 1'b0, sr: 1'b0, fs: 2'b00};
      endcase
      return p;
   endfunction

   function automatic logic rate_valid(input logic [15:0] code);
      pll_pins_t p;
      p = rate_to_pins(code);
      return p.valid;
   endfunction

endpackage

// File: rtl/dev_mode_debounce.sv
// Registers the requested rate code and emits a one-cycle accept once it has been
// sampled STABLE_CYCLES times in a row.
module dev_mode_debounce
   import dev_audio_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_mode,
   output logic        o_accept,
   output logic [15:0] o_code
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES);

   logic [15:0]   r_mode_q;
   logic [SW-1:0] r_cnt;
   logic          r_accept;
   logic          w_change;
   logic [SW-1:0] w_cnt_nxt;

   assign w_change = (i_mode != r_mode_q);

   always_comb begin
      if (w_change)
         w_cnt_nxt = SW'(1);
      else if (r_cnt == SMAX)
         w_cnt_nxt = SMAX;
      else
         w_cnt_nxt = r_cnt + SW'(1);
   end

   // Reset looks like a long-held 48k request so it is never re-accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode_q <= FREQ_48K;
         r_cnt    <= SMAX;
         r_accept <= 1'b0;
      end else begin
         r_mode_q <= i_mode;
         r_cnt    <= w_cnt_nxt;
         r_accept <= (w_cnt_nxt == SMAX) && (w_change || (r_cnt != SMAX));
      end
   end

   assign o_accept = r_accept;
   assign o_code   = r_mode_q;

endmodule

// File: rtl/dev_pll_rate_ctrl.sv
// Mute / reprogram / settle / unmute sequencer driving the PLL rate pins (fs, sr)
// from a debounced audio_freq_mode request.
module dev_pll_rate_ctrl
   import dev_audio_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int MUTE_CYCLES   = 256,
   parameter int SETTLE_CYCLES = 65536,
   parameter int CNT_W         = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] audio_freq_mode,
   output logic [2:1]  fs,
   output logic        sr,
   output logic        mute,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] cur_mode
);

   if ((STABLE_CYCLES < 1) || (MUTE_CYCLES < 1) || (SETTLE_CYCLES < 1) ||
       (longint'(MUTE_CYCLES) >= (longint'(1) << CNT_W)) ||
       (longint'(SETTLE_CYCLES) >= (longint'(1) << CNT_W))) begin : g_param_err
      $error("dev_pll_rate_ctrl: bad cycle counts or CNT_W too narrow");
   end

   localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(MUTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_timer;
   logic [15:0]      r_target;
   logic [15:0]      r_cur;
   logic [1:0]       r_fs;
   logic             r_sr;
   logic             r_mute;
   logic             r_done;
   logic             r_err;

   logic             w_accept;
   logic [15:0]      w_code;
   logic             w_code_ok;
   logic             w_new;
   logic [15:0]      w_target_nxt;
   pll_pins_t        w_prog;

   dev_mode_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .i_mode   (audio_freq_mode),
      .o_accept (w_accept),
      .o_code   (w_code)
   );

   assign w_code_ok    = rate_valid(w_code);
   assign w_new        = w_accept && w_code_ok && (w_code != r_target);
   assign w_target_nxt = w_new ? w_code : r_target;
   // A request landing in PROG itself is programmed straight away.
   assign w_prog       = rate_to_pins(w_target_nxt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_SETTLE;
         r_timer  <= '0;
         r_target <= FREQ_48K;
         r_cur    <= FREQ_48K;
         r_fs     <= 2'b00;
         r_sr     <= 1'b0;
         r_mute   <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_err    <= w_accept && !w_code_ok;
         r_target <= w_target_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_new) begin
                  r_state <= ST_MUTE;
                  r_mute  <= 1'b1;
                  r_timer <= '0;
               end
            end
            ST_MUTE: begin
               if (r_timer == MUTE_LAST) begin
                  r_state <= ST_PROG;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_PROG: begin
               if (w_prog.valid) begin
                  r_fs  <= w_prog.fs;
                  r_sr  <= w_prog.sr;
                  r_cur <= w_target_nxt;
               end
               r_timer <= '0;
               r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (w_new) begin
                  r_state <= ST_PROG;
                  r_timer <= '0;
               end else if (r_timer == SETTLE_LAST) begin
                  r_state <= ST_IDLE;
                  r_mute  <= 1'b0;
                  r_done  <= 1'b1;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fs       = r_fs;
   assign sr       = r_sr;
   assign mute     = r_mute;
   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign err      = r_err;
   assign cur_mode = r_cur;

endmodule

// File: tb/tb_dev_pll_rate_ctrl.sv
// Bench for dev_pll_rate_ctrl: event-time reference model checked every cycle,
// a pin-map vector table, hand sequences and randomized rate requests.
module tb_dev_pll_rate_ctrl;

   localparam int STABLE = 3;
   localparam int MUTEC  = 4;
   localparam int SETTLE = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] mode_in = 16'h3;
   logic [2:1]  fs;
   logic        sr, mute, busy, done, err;
   logic [15:0] cur_mode;

   dev_pll_rate_ctrl #(
      .STABLE_CYCLES(STABLE), .MUTE_CYCLES(MUTEC), .SETTLE_CYCLES(SETTLE), .CNT_W(5)
   ) dut (
      .clk(clk), .rst(rst), .audio_freq_mode(mode_in), .fs(fs), .sr(sr),
      .mute(mute), .busy(busy), .done(done), .err(err), .cur_mode(cur_mode)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_err = 0;

   // Reference model: sequence milestones as absolute cycle numbers.
   int          k, t_prog, t_done, err_at, run;
   logic [15:0] target, exp_cur, last_in, acc_code;
   bit          acc_pend;

   function automatic bit ref_valid(input logic [15:0] c);
      return (c >= 16'd1) && (c <= 16'd6);
   endfunction

   function automatic logic [2:0] ref_pins(input logic [15:0] c);
      case (c)
         16'd1:   return 3'b0_10;
         16'd2:   return 3'b0_01;
         16'd4:   return 3'b1_00;
         16'd5:   return 3'b1_10;
         16'd6:   return 3'b1_01;
         default: return 3'b0_00;
      endcase
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, k, act, exp);
      end
   endtask

   task automatic model_init();
      k = 0; t_prog = -1; t_done = SETTLE; err_at = -1;
      target = 16'h3; exp_cur = 16'h3; last_in = 16'h3; run = STABLE; acc_pend = 0;
      acc_code = 16'h3;
   endtask

   task automatic body(input logic [15:0] v);
      logic [2:0] ep;
      if (k == t_prog + 1) exp_cur = target;
      ep = ref_pins(exp_cur);
      check("mute", {15'd0, mute}, {15'd0, (k < t_done)});
      check("busy", {15'd0, busy}, {15'd0, (k < t_done)});
      check("done", {15'd0, done}, {15'd0, (k == t_done)});
      check("err", {15'd0, err}, {15'd0, (k == err_at)});
      check("sr", {15'd0, sr}, {15'd0, ep[2]});
      check("fs", {14'd0, fs}, {14'd0, ep[1:0]});
      check("cur_mode", cur_mode, exp_cur);
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      if (acc_pend) begin
         if (!ref_valid(acc_code)) err_at = k + 1;
         else if (acc_code != target) begin
            target = acc_code;
            if (k >= t_done) begin
               t_prog = k + 1 + MUTEC;
               t_done = k + 2 + MUTEC + SETTLE;
            end else if (k > t_prog) begin
               t_prog = k + 1;
               t_done = k + 2 + SETTLE;
            end
         end
      end
      if (v != last_in) begin
         last_in = v;
         run = 1;
      end else begin
         run++;
      end
      acc_pend = (run == STABLE);
      acc_code = last_in;
      mode_in = v;
      k++;
   endtask

   task automatic run_for(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         body(v);
      end
   endtask

   task automatic release_reset(input logic [15:0] v);
      @(negedge clk);
      rst = 1'b0;
      model_init();
      body(v);
   endtask

   typedef struct {
      logic [15:0] code;
      logic [15:0] cur;
      logic        sr;
      logic [1:0]  fs;
      int          errs;
      int          dones;
   } vec_t;

   vec_t vecs[8];
   logic [15:0] pool[10];

   initial begin
      vecs[0] = '{16'h4, 16'h4, 1'b1, 2'b00, 0, 1};
      vecs[1] = '{16'h1, 16'h1, 1'b0, 2'b10, 0, 1};
      vecs[2] = '{16'h5, 16'h5, 1'b1, 2'b10, 0, 1};
      vecs[3] = '{16'h6, 16'h6, 1'b1, 2'b01, 0, 1};
      vecs[4] = '{16'h2, 16'h2, 1'b0, 2'b01, 0, 1};
      vecs[5] = '{16'h9, 16'h2, 1'b0, 2'b01, 1, 0};
      vecs[6] = '{16'h2, 16'h2, 1'b0, 2'b01, 0, 0};
      vecs[7] = '{16'h3, 16'h3, 1'b0, 2'b00, 0, 1};
      pool = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h0, 16'h9, 16'hFFFF, 16'h2};

      model_init();
      repeat (3) @(posedge clk);
      release_reset(16'h3);
      run_for(16'h3, 14);

      for (int i = 0; i < 8; i++) begin
         int d0, e0;
         d0 = n_done; e0 = n_err;
         run_for(vecs[i].code, 24);
         check("vec_sr", {15'd0, sr}, {15'd0, vecs[i].sr});
         check("vec_fs", {14'd0, fs}, {14'd0, vecs[i].fs});
         check("vec_cur", cur_mode, vecs[i].cur);
         check("vec_busy", {15'd0, busy}, 16'd0);
         check("vec_errs", 16'(n_err - e0), 16'(vecs[i].errs));
         check("vec_dones", 16'(n_done - d0), 16'(vecs[i].dones));
      end

      begin
         int d0;
         run_for(16'h1, 1); run_for(16'h2, 1); run_for(16'h1, 1); run_for(16'h2, 1);
         d0 = n_done;
         run_for(16'h5, 24);
         check("toggle_dones", 16'(n_done - d0), 16'd1);
         check("toggle_cur", cur_mode, 16'h5);
         check("toggle_pins", {13'd0, sr, fs}, 16'b1_10);
      end

      begin
         int d0;
         run_for(16'h2, 10);
         check("ovl_first_pins", {13'd0, sr, fs}, 16'b0_01);
         d0 = n_done;
         run_for(16'h6, 20);
         check("ovl_dones", 16'(n_done - d0), 16'd1);
         check("ovl_pins", {13'd0, sr, fs}, 16'b1_01);
      end

      run_for(16'h1, 6);
      check("pre_rst_mute", {15'd0, mute}, 16'd1);
      #2;
      rst = 1'b1;
      mode_in = 16'h3;
      #1;
      check("rst_fs", {14'd0, fs}, 16'd0);
      check("rst_sr", {15'd0, sr}, 16'd0);
      check("rst_mute", {15'd0, mute}, 16'd1);
      check("rst_busy", {15'd0, busy}, 16'd1);
      check("rst_cur", cur_mode, 16'h3);
      check("rst_done", {15'd0, done}, 16'd0);
      @(posedge clk);
      release_reset(16'h3);
      run_for(16'h3, 14);

      for (int s = 0; s < 60; s++) begin
         run_for(pool[$urandom_range(0, 9)], int'($urandom_range(1, 30)));
      end
      run_for(16'h3, 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
